part_1_init_xchg: RTL

Initiator-side vector exchange controller for the split-simulation bridge. On each rising edge of the mission clock `clk_0_h` it snapshots the three downstream stimulus vectors and pushes them, one per channel, to the transport. It then freezes the mission clock until the target returns its output vector, and presents that vector to the initiator-side logic. It is the counterpart of the target-side fringe interface and sits between the initiator partition and the transport FIFO.

---
 rtl/part_1_init_xchg_if.sv | 22 ++
 rtl/part_1_init_xchg.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/part_1_init_xchg_if.sv
// Transport-side handshake bundle for the initiator vector exchange controller.
// The controller drives the put side and consumes the get side through the master modport.
interface part_1_init_xchg_if #(
  parameter int unsigned N = 9
);
  logic         put_valid;
  logic         put_ready;
  logic [1:0]   put_ch;
  logic [N-1:0] put_data;
  logic         get_valid;
  logic [N-1:0] get_data;

  modport master (
    output put_valid, put_ch, put_data,
    input  put_ready, get_valid, get_data
  );

  modport slave (
    input  put_valid, put_ch, put_data,
    output put_ready, get_valid, get_data
  );
endinterface

// File: rtl/part_1_init_xchg.sv
// Initiator-side vector exchange: snapshot stimulus on each mission-clock rise, push it per channel,
// freeze the mission clock until the target response returns. Optional macro: PART_1_INIT_XCHG_DBG_VECT_EN.
module part_1_init_xchg #(
  parameter int unsigned N      = 9,
  parameter int unsigned NCH    = 3,
  parameter int unsigned WD_MAX = 10000,
  parameter int unsigned WD_W   = 14
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clk_0_h,
  input  logic               wen0,
  input  logic               wen1,
  input  logic               wen2,
  input  logic [7:0]         i_data0,
  input  logic [7:0]         i_data1,
  input  logic [7:0]         i_data2,
  part_1_init_xchg_if.master xchg,
  output logic               valid,
  output logic [7:0]         o_data,
  output logic               freeze_clk,
  output logic               busy,
  output logic               wd_err,
  output logic               ovr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RSP,
    S_ERROR
  } state_t;

`ifdef PART_1_INIT_XCHG_DBG_VECT_EN
  localparam logic [1:0] LAST_CH = 2'(NCH);
`else
  localparam logic [1:0] LAST_CH = 2'(NCH - 1);
`endif
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WD_MAX);

  state_t          r_state;
  state_t          w_state_nx;

  logic            r_clk0_s;
  logic            r_clk0_d;
  logic            r_edge;
  logic [1:0]      r_ch_cnt;
  logic [WD_W-1:0] r_wd;
  logic [N-1:0]    r_shadow0;
  logic [N-1:0]    r_shadow1;
  logic [N-1:0]    r_shadow2;
`ifdef PART_1_INIT_XCHG_DBG_VECT_EN
  logic [N-1:0]    r_vect_dbg;
`endif

  logic            w_capture;
  logic            w_put_vld;
  logic            w_put_fire;
  logic            w_last;
  logic            w_rsp_ok;
  logic            w_timeout;
  logic            w_wd_inc;
  logic [N-1:0]    w_put_data;

  assign w_last     = (r_ch_cnt == LAST_CH);
  assign w_put_fire = w_put_vld & xchg.put_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_capture  = 1'b0;
    w_put_vld  = 1'b0;
    w_rsp_ok   = 1'b0;
    w_timeout  = 1'b0;
    w_wd_inc   = 1'b0;
    freeze_clk = 1'b1;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        freeze_clk = 1'b0;
        busy       = 1'b0;
        if (r_edge) begin
          w_capture  = 1'b1;
          w_state_nx = S_SEND;
        end
      end
      S_SEND: begin
        w_put_vld = 1'b1;
        if (xchg.put_ready && w_last) w_state_nx = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        // A response arriving on the timeout cycle still counts as success.
        if (xchg.get_valid) begin
          w_rsp_ok   = 1'b1;
          w_state_nx = S_IDLE;
        end else if (r_wd == WD_LIM) begin
          w_timeout  = 1'b1;
          w_state_nx = S_ERROR;
        end else begin
          w_wd_inc = 1'b1;
        end
      end
      S_ERROR: begin
        w_state_nx = S_ERROR;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_put_data = '0;
    if (w_put_vld) begin
      case (r_ch_cnt)
        2'd0:    w_put_data = r_shadow0;
        2'd1:    w_put_data = r_shadow1;
        2'd2:    w_put_data = r_shadow2;
`ifdef PART_1_INIT_XCHG_DBG_VECT_EN
        default: w_put_data = r_vect_dbg;
`else
        default: w_put_data = '0;
`endif
      endcase
    end
  end

  assign xchg.put_valid = w_put_vld;
  assign xchg.put_ch    = w_put_vld ? r_ch_cnt : 2'd0;
  assign xchg.put_data  = w_put_data;

  // clk_0_h is sampled once before the delay stage so the edge pulse sees a registered copy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_clk0_s <= 1'b0;
      r_clk0_d <= 1'b0;
      r_edge   <= 1'b0;
    end else begin
      r_clk0_s <= clk_0_h;
      r_clk0_d <= r_clk0_s;
      r_edge   <= r_clk0_s & ~r_clk0_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shadow0 <= '0;
      r_shadow1 <= '0;
      r_shadow2 <= '0;
    end else if (w_capture) begin
      r_shadow0 <= {wen0, i_data0};
      r_shadow1 <= {wen1, i_data1};
      r_shadow2 <= {wen2, i_data2};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ch_cnt <= '0;
    end else if (w_capture) begin
      r_ch_cnt <= '0;
    end else if (w_put_fire && !w_last) begin
      r_ch_cnt <= r_ch_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wd <= '0;
    end else if (w_put_fire && w_last) begin
      r_wd <= '0;
    end else if (w_wd_inc) begin
      r_wd <= r_wd + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid  <= 1'b0;
      o_data <= '0;
    end else if (w_rsp_ok) begin
      valid  <= xchg.get_data[8];
      o_data <= xchg.get_data[7:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_err <= 1'b0;
      ovr    <= 1'b0;
    end else begin
      if (w_timeout) wd_err <= 1'b1;
      if (r_edge && (r_state != S_IDLE)) ovr <= 1'b1;
    end
  end

`ifdef PART_1_INIT_XCHG_DBG_VECT_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         r_vect_dbg <= '0;
    else if (w_rsp_ok) r_vect_dbg <= r_vect_dbg + 1'b1;
  end
`endif

endmodule
